// File: rtl/settings_pkg.sv
// Shared types and constants for the settings menu: FSM states, field codes,
// legal setting values and the per-field wrap limits.
package settings_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEL_MODE  = 2'd1,
        SEL_DIFF  = 2'd2,
        SEL_SPEED = 2'd3
    } state_t;

    localparam logic [1:0] FIELD_NONE  = 2'd0;
    localparam logic [1:0] FIELD_MODE  = 2'd1;
    localparam logic [1:0] FIELD_DIFF  = 2'd2;
    localparam logic [1:0] FIELD_SPEED = 2'd3;

    localparam logic [1:0] MODE_SOLO   = 2'd0;
    localparam logic [1:0] MODE_TWO    = 2'd1;
    localparam logic [2:0] DIFF_EASY   = 3'd0;
    localparam logic [2:0] DIFF_MEDIUM = 3'd1;
    localparam logic [2:0] DIFF_HARD   = 3'd2;
    localparam logic [1:0] SPEED_SLOW  = 2'd0;
    localparam logic [1:0] SPEED_FAST  = 2'd1;

    localparam logic [1:0] MODE_MAX  = MODE_TWO;
    localparam logic [2:0] DIFF_MAX  = DIFF_HARD;
    localparam logic [1:0] SPEED_MAX = SPEED_FAST;

    // Increment with wrap to zero; ">=" keeps any out-of-range value legal.
    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input logic [2:0] max);
        return (v >= max) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw button: a single registered press pulse after DEBOUNCE_CYC
// stable-high samples, re-armed only after DEBOUNCE_CYC stable-low samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          armed;
    logic [CW-1:0] cnt;
    logic          cnt_last;

    assign cnt_last = (cnt == CW'(DEBOUNCE_CYC - 1));

    // Starts disarmed so a button already held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (armed == btn) begin
                if (cnt_last) begin
                    cnt   <= '0;
                    armed <= ~armed;
                    press <= armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/settings_ctrl.sv
// Game settings menu: debounced buttons drive an edit FSM over shadow copies
// of mode/difficulty/speed, committed to cfg_* only on confirm.
module settings_ctrl
    import settings_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_confirm,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       game_active,
    output logic [1:0] cfg_mode,
    output logic [2:0] cfg_difficulty,
    output logic [1:0] cfg_speed,
    output logic [1:0] edit_field,
    output logic [2:0] edit_value,
    output logic       cfg_update
);
    logic p_confirm, p_next, p_inc;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_confirm (.clk(clk), .rst(rst), .btn(btn_confirm), .press(p_confirm));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next    (.clk(clk), .rst(rst), .btn(btn_next),    .press(p_next));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc     (.clk(clk), .rst(rst), .btn(btn_inc),     .press(p_inc));

    state_t     state, state_n;
    logic [1:0] sh_mode, sh_mode_n, cfg_mode_n, sh_speed, sh_speed_n, cfg_speed_n;
    logic [2:0] sh_diff, sh_diff_n, cfg_diff_n;
    logic [1:0] edit_field_n;
    logic [2:0] edit_value_n;
    logic       cfg_update_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sh_mode        <= MODE_SOLO;
            sh_diff        <= DIFF_EASY;
            sh_speed       <= SPEED_SLOW;
            cfg_mode       <= MODE_SOLO;
            cfg_difficulty <= DIFF_EASY;
            cfg_speed      <= SPEED_SLOW;
            edit_field     <= FIELD_NONE;
            edit_value     <= 3'd0;
            cfg_update     <= 1'b0;
        end else begin
            state          <= state_n;
            sh_mode        <= sh_mode_n;
            sh_diff        <= sh_diff_n;
            sh_speed       <= sh_speed_n;
            cfg_mode       <= cfg_mode_n;
            cfg_difficulty <= cfg_diff_n;
            cfg_speed      <= cfg_speed_n;
            edit_field     <= edit_field_n;
            edit_value     <= edit_value_n;
            cfg_update     <= cfg_update_n;
        end
    end

    always_comb begin
        state_n      = state;
        sh_mode_n    = sh_mode;
        sh_diff_n    = sh_diff;
        sh_speed_n   = sh_speed;
        cfg_mode_n   = cfg_mode;
        cfg_diff_n   = cfg_difficulty;
        cfg_speed_n  = cfg_speed;
        cfg_update_n = 1'b0;

        if (state == IDLE) begin
            if (p_confirm && !game_active) begin
                state_n    = SEL_MODE;
                sh_mode_n  = cfg_mode;
                sh_diff_n  = cfg_difficulty;
                sh_speed_n = cfg_speed;
            end
        end else if (game_active) begin
            // Abort beats a same-cycle confirm; stale shadows are reloaded on next entry.
            state_n = IDLE;
        end else if (p_confirm) begin
            state_n      = IDLE;
            cfg_mode_n   = sh_mode;
            cfg_diff_n   = sh_diff;
            cfg_speed_n  = sh_speed;
            cfg_update_n = 1'b1;
        end else if (p_next) begin
            case (state)
                SEL_MODE: state_n = SEL_DIFF;
                SEL_DIFF: state_n = SEL_SPEED;
                default:  state_n = SEL_MODE;
            endcase
        end else if (p_inc) begin
            case (state)
                SEL_MODE: sh_mode_n  = 2'(wrap_inc({1'b0, sh_mode}, {1'b0, MODE_MAX}));
                SEL_DIFF: sh_diff_n  = wrap_inc(sh_diff, DIFF_MAX);
                default:  sh_speed_n = 2'(wrap_inc({1'b0, sh_speed}, {1'b0, SPEED_MAX}));
            endcase
        end

        edit_field_n = FIELD_NONE;
        edit_value_n = 3'd0;
        case (state_n)
            SEL_MODE:  begin edit_field_n = FIELD_MODE;  edit_value_n = {1'b0, sh_mode_n};  end
            SEL_DIFF:  begin edit_field_n = FIELD_DIFF;  edit_value_n = sh_diff_n;          end
            SEL_SPEED: begin edit_field_n = FIELD_SPEED; edit_value_n = {1'b0, sh_speed_n}; end
            default:   ;
        endcase
    end

endmodule
